// File: rtl/tone_seq_ctrl.sv
// tone_seq_ctrl
// Sequencer for the quadrature tone source feeding the speech front end.
// Each sample period produces one signed sine/cosine pair. The pair is built
// from two reads of a shared quarter-wave ROM (1-cycle read latency), has its
// sign restored, and is then offered to the filter bank with a valid/ready
// hand-off. The block runs bursts of burst_len pairs, or runs continuously
// when burst_len is 0, under start/stop control.
//
// Handshake: a pair transfers on any rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_valid, sin_out and
// cos_out hold steady until that transfer.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, stop         control pulses (stop wins if both are high together)
//   freq_word           phase increment per sample (latched at start)
//   burst_len           pairs per burst, 0 = continuous (latched at start)
//   rom_en, rom_addr    quarter-wave ROM read strobe and address
//   rom_data            ROM magnitude, valid the cycle after rom_en
//   sin_out, cos_out    signed sample pair
//   out_valid/out_ready output handshake
//   busy, done          activity flag and 1-cycle end-of-run pulse
//   overrun             sticky: a sample tick was dropped while a pair was in flight
//   dbg_state           current FSM state, for observation only
module tone_seq_ctrl #(
    parameter int PHASE_W  = 24,
    parameter int LUT_AW   = 8,
    parameter int DATA_W   = 16,
    parameter int TICK_DIV = 6250
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [PHASE_W-1:0]       freq_word,
    input  logic [15:0]              burst_len,
    output logic                     rom_en,
    output logic [LUT_AW-1:0]        rom_addr,
    input  logic [DATA_W-2:0]        rom_data,
    output logic signed [DATA_W-1:0] sin_out,
    output logic signed [DATA_W-1:0] cos_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic [2:0]               dbg_state
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        RD_SIN    = 3'd2,
        RD_COS    = 3'd3,
        CAP       = 3'd4,
        PRESENT   = 3'd5
    } state_t;

    state_t              state, state_next;
    logic [TCW-1:0]      tick_cnt;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  freq_l;
    logic [15:0]         len_l;
    logic [15:0]         cnt;
    logic                stop_pend;
    logic [DATA_W-2:0]   sin_mag;

    logic                tick;
    logic                start_go;
    logic                hs;
    logic                stop_now;
    logic [1:0]          q_sin;
    logic [1:0]          q_cos;
    logic [LUT_AW-1:0]   idx;

    assign tick     = (state != IDLE) && (tick_cnt == TCW'(TICK_DIV - 1));
    assign start_go = (state == IDLE) && start && !stop;
    assign hs       = (state == PRESENT) && out_ready;
    assign stop_now = stop || stop_pend;

    // The cosine phase is the sine phase plus a quarter turn. Adding a quarter
    // turn only increments the quadrant bits, so the ROM index is shared.
    assign q_sin = phase[PHASE_W-1 -: 2];
    assign q_cos = q_sin + 2'd1;
    assign idx   = phase[PHASE_W-3 -: LUT_AW];

    function automatic logic [DATA_W-1:0] restore(input logic [DATA_W-2:0] mag,
                                                  input logic neg);
        logic [DATA_W-1:0] ext;
        ext = {1'b0, mag};
        return neg ? (DATA_W'(0) - ext) : ext;
    endfunction

    always_comb begin
        state_next = state;
        rom_en     = 1'b0;
        rom_addr   = '0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        dbg_state  = state;
        case (state)
            IDLE: begin
                if (start_go) state_next = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (stop_now)  state_next = IDLE;
                else if (tick) state_next = RD_SIN;
            end
            RD_SIN: begin
                rom_en     = 1'b1;
                rom_addr   = q_sin[0] ? ~idx : idx;
                state_next = RD_COS;
            end
            RD_COS: begin
                rom_en     = 1'b1;
                rom_addr   = q_cos[0] ? ~idx : idx;
                state_next = CAP;
            end
            CAP: begin
                state_next = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // cnt == 1 here means this handshake brings the count to 0.
                    if (stop_now || ((len_l != 16'd0) && (cnt == 16'd1)))
                        state_next = IDLE;
                    else
                        state_next = WAIT_TICK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            phase     <= '0;
            freq_l    <= '0;
            len_l     <= '0;
            cnt       <= '0;
            stop_pend <= 1'b0;
            sin_mag   <= '0;
            sin_out   <= '0;
            cos_out   <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state != IDLE) && (state_next == IDLE);

            if (state == IDLE)  tick_cnt <= '0;
            else if (tick)      tick_cnt <= '0;
            else                tick_cnt <= tick_cnt + TCW'(1);

            if (start_go) begin
                phase     <= '0;
                freq_l    <= freq_word;
                len_l     <= burst_len;
                cnt       <= burst_len;
                overrun   <= 1'b0;
                stop_pend <= 1'b0;
            end else begin
                if (state_next == IDLE)              stop_pend <= 1'b0;
                else if (state != IDLE && stop)      stop_pend <= 1'b1;

                // A tick outside WAIT_TICK is dropped; record that it happened.
                if (tick && state != WAIT_TICK)      overrun <= 1'b1;

                if (hs) begin
                    phase <= phase + freq_l;
                    cnt   <= cnt - 16'd1;
                end
            end

            if (state == RD_COS) sin_mag <= rom_data;
            if (state == CAP) begin
                sin_out <= restore(sin_mag, q_sin[1]);
                cos_out <= restore(rom_data, q_cos[1]);
            end
        end
    end

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Directed bench for tone_seq_ctrl with a ramp ROM (rom[i] = i), TICK_DIV = 8.
module tb_tone_seq_ctrl;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic [23:0]        freq_word;
    logic [15:0]        burst_len;
    logic               rom_en;
    logic [7:0]         rom_addr;
    logic [14:0]        rom_data = '0;
    logic signed [15:0] sin_out;
    logic signed [15:0] cos_out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic               overrun;
    logic [2:0]         dbg_state;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int rom_cnt = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] act_q[$];

    tone_seq_ctrl #(
        .PHASE_W(24), .LUT_AW(8), .DATA_W(16), .TICK_DIV(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .freq_word(freq_word), .burst_len(burst_len),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .sin_out(sin_out), .cos_out(cos_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overrun(overrun), .dbg_state(dbg_state)
    );

    // Clock and ROM model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) begin
        if (rom_en) rom_data <= 15'(rom_addr);
    end

    // Activity monitor: runs 2 units after the falling edge, after the driver.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (rom_en) rom_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                act_q.push_back({sin_out, cos_out});
            end
        end
    end

    // Driver and check tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [23:0] f, input logic [15:0] n);
        freq_word = f;
        burst_len = n;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic exp_pair(input int s, input int c);
        exp_q.push_back({16'(s), 16'(c)});
    endtask

    task automatic check_pairs(input string tag);
        logic [31:0] e, a;
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            chk(tag, a, e);
        end
        exp_q.delete();
        act_q.delete();
    endtask

    initial begin
        int base_hs, base_done, base_rom;
        int rom_first, rom_last, rom_n, first_v, cyc;
        logic d12, b12, d13, stable;
        logic signed [15:0] s0, c0;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        freq_word = '0; burst_len = '0; out_ready = 1'b1;
        step(); step();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_sin", sin_out, 0);
        chk("rst_cos", cos_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        step();

        // Burst of 4 quarter-turn steps
        base_hs = hs_cnt; base_done = done_cnt;
        start_burst(24'h400000, 16'd4);
        chk("s1_busy", busy, 1);
        for (int i = 0; i < 200 && busy; i++) step();
        chk("s1_idle", busy, 0);
        step(); step();
        chk("s1_hs", hs_cnt - base_hs, 4);
        chk("s1_done", done_cnt - base_done, 1);
        exp_pair(0, 255); exp_pair(255, 0); exp_pair(0, -255); exp_pair(-255, 0);
        check_pairs("s1_pair");

        // Tick-relative timing of rom_en / out_valid / done, single pair
        base_rom = rom_cnt;
        start_burst(24'h400000, 16'd1);
        rom_first = -1; rom_last = -1; rom_n = 0; first_v = -1;
        d12 = 1'b0; b12 = 1'b1; d13 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (rom_en) begin
                if (rom_first < 0) rom_first = c;
                rom_last = c;
                rom_n++;
            end
            if (out_valid && first_v < 0) first_v = c;
            if (c == 12) begin d12 = done; b12 = busy; end
            if (c == 13) d13 = done;
            step();
        end
        chk("s4_rom_first", rom_first, 8);
        chk("s4_rom_last", rom_last, 9);
        chk("s4_rom_n", rom_n, 2);
        chk("s4_valid_at", first_v, 11);
        chk("s4_done_pulse", d12, 1);
        chk("s4_busy_low", b12, 0);
        chk("s4_done_clear", d13, 0);
        step();
        chk("s4_rom_total", rom_cnt - base_rom, 2);
        exp_pair(0, 255);
        check_pairs("s4_pair");

        // Continuous run with phase wrap, stop issued during the 5th read
        base_hs = hs_cnt; base_done = done_cnt; base_rom = rom_cnt;
        start_burst(24'hC00000, 16'd0);
        for (int i = 0; i < 200 && (hs_cnt - base_hs) < 4; i++) step();
        for (int i = 0; i < 50 && !rom_en; i++) step();
        chk("s2_rom_seen", rom_en, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s2_still_busy", busy, 1);
        for (int i = 0; i < 100 && busy; i++) step();
        chk("s2_idle", busy, 0);
        for (int i = 0; i < 20; i++) step();
        chk("s2_hs", hs_cnt - base_hs, 5);
        chk("s2_done", done_cnt - base_done, 1);
        chk("s2_rom", rom_cnt - base_rom, 10);
        exp_pair(0, 255); exp_pair(-255, 0); exp_pair(0, -255);
        exp_pair(255, 0); exp_pair(0, 255);
        check_pairs("s2_pair");

        // Back-pressure: hold out_ready low for 20 cycles
        out_ready = 1'b0;
        start_burst(24'h400000, 16'd2);
        cyc = 0;
        while (!out_valid && cyc < 40) begin step(); cyc++; end
        chk("s3_valid_at", cyc, 11);
        chk("s3_sin0", sin_out, 0);
        chk("s3_cos0", cos_out, 255);
        s0 = sin_out; c0 = cos_out; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (sin_out !== s0 || cos_out !== c0 || out_valid !== 1'b1 || rom_en !== 1'b0)
                stable = 1'b0;
        end
        chk("s3_stable", stable, 1);
        chk("s3_overrun", overrun, 1);
        out_ready = 1'b1;
        step(); cyc++;
        while (!rom_en && cyc < 60) begin step(); cyc++; end
        chk("s3_next_rom", cyc, 40);
        while (!out_valid && cyc < 60) begin step(); cyc++; end
        chk("s3_next_valid", cyc, 43);
        chk("s3_sin1", sin_out, 255);
        chk("s3_cos1", cos_out, 0);
        step();
        chk("s3_done", done, 1);
        chk("s3_busy", busy, 0);
        step(); step();
        exp_pair(0, 255); exp_pair(255, 0);
        check_pairs("s3_pair");

        // Stop while waiting for a tick; then start+stop together in IDLE
        start_burst(24'h400000, 16'd0);
        chk("s5_overrun_clr", overrun, 0);
        step(); step(); step();
        base_rom = rom_cnt;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s5_done", done, 1);
        chk("s5_busy", busy, 0);
        for (int i = 0; i < 20; i++) step();
        chk("s5_no_rom", rom_cnt - base_rom, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step(); step();
        chk("s5_both_busy", busy, 0);
        chk("s5_both_state", dbg_state, 0);

        // Asynchronous reset during RD_COS
        start_burst(24'h400000, 16'd3);
        for (int i = 0; i < 20 && !rom_en; i++) step();
        step();
        chk("s6_in_rd_cos", dbg_state, 3);
        base_done = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("s6_rom_en", rom_en, 0);
        chk("s6_rom_addr", rom_addr, 0);
        chk("s6_busy", busy, 0);
        chk("s6_valid", out_valid, 0);
        chk("s6_sin", sin_out, 0);
        chk("s6_cos", cos_out, 0);
        chk("s6_done", done, 0);
        step(); step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("s6_no_done", done_cnt - base_done, 0);
        start_burst(24'h400000, 16'd1);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk("s6_restart_sin", sin_out, 0);
        chk("s6_restart_cos", cos_out, 255);
        step(); step();
        exp_pair(0, 255);
        check_pairs("s6_pair");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
